// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter
// Two-source round-robin arbiter with one-word holding slots, feeding the
// A/B data inputs and S select of a downstream 2:1 mux. The consumer of the
// mux output sees a valid/ready handshake (out_valid/out_ready).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a_valid/a_ready/a_data  source A offer / accept / word
//   b_valid/b_ready/b_data  source B offer / accept / word
//   A, B                  holding registers driven to mux inputs
//   S                     mux select (0 = A, 1 = B)
//   out_valid/out_ready   mux output handshake
//
// Build option: define MUXARB_BURST_EN to let a source keep the grant for up
// to BURST consecutive transfers while the other source waits. Without it the
// grant alternates after every transfer whenever the other slot is full.
module mux_sel_arbiter #(
    parameter int WIDTH = 2,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             S,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2} state_t;

    state_t           r_state;
    logic             r_a_full, r_b_full;
    logic             r_last;              // 0: A granted last, 1: B granted last
    logic             r_s;
    logic [WIDTH-1:0] r_a, r_b;

    logic w_xfer, w_a_rel, w_b_rel, w_a_acc, w_b_acc;
    logic w_refill, w_other_full, w_yield, w_switch;

    generate
        if (BURST < 1 || BURST > 15) begin : g_bad_burst
            $error("mux_sel_arbiter: BURST must be in 1..15");
        end
    endgenerate

    assign out_valid = (r_state != IDLE);
    assign w_xfer    = out_valid && out_ready;
    assign w_a_rel   = (r_state == GNT_A) && w_xfer;
    assign w_b_rel   = (r_state == GNT_B) && w_xfer;

    // A slot can take a new word while its current word leaves.
    assign a_ready = !r_a_full || w_a_rel;
    assign b_ready = !r_b_full || w_b_rel;
    assign w_a_acc = a_valid && a_ready;
    assign w_b_acc = b_valid && b_ready;

    // Granted-slot view: is the granted slot refilled, is the other one waiting.
    assign w_refill     = (r_state == GNT_B) ? w_b_acc  : w_a_acc;
    assign w_other_full = (r_state == GNT_B) ? r_a_full : r_b_full;

    // Hand the grant over when the other side waits and we either run dry
    // or have used up our burst allowance.
    assign w_switch = w_xfer && w_other_full && (!w_refill || w_yield);

`ifdef MUXARB_BURST_EN
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_inc;

    // Saturating at BURST keeps the yield test true if the other source
    // shows up after a long solo run.
    assign w_cnt_inc = (r_cnt == 4'(BURST)) ? r_cnt : r_cnt + 4'd1;
    assign w_yield   = (w_cnt_inc == 4'(BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_xfer) begin
            r_cnt <= (w_refill && !w_switch) ? w_cnt_inc : 4'd0;
        end
    end
`else
    assign w_yield = 1'b1;
`endif

    // Holding slots. Data is never cleared by a transfer, only overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
        end else begin
            if (w_a_acc) begin
                r_a      <= a_data;
                r_a_full <= 1'b1;
            end else if (w_a_rel) begin
                r_a_full <= 1'b0;
            end
            if (w_b_acc) begin
                r_b      <= b_data;
                r_b_full <= 1'b1;
            end else if (w_b_rel) begin
                r_b_full <= 1'b0;
            end
        end
    end

    // Grant FSM. S and last only change when a grant is (re)issued, so
    // they are frozen through stalls and S holds in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_s     <= 1'b0;
            r_last  <= 1'b1;   // A wins the first tie
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_a_full && (!r_b_full || r_last)) begin
                        r_state <= GNT_A;
                        r_s     <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (r_b_full) begin
                        r_state <= GNT_B;
                        r_s     <= 1'b1;
                        r_last  <= 1'b1;
                    end
                end
                GNT_A: begin
                    if (w_switch) begin
                        r_state <= GNT_B;
                        r_s     <= 1'b1;
                        r_last  <= 1'b1;
                    end else if (w_xfer && !w_a_acc) begin
                        r_state <= IDLE;
                    end
                end
                GNT_B: begin
                    if (w_switch) begin
                        r_state <= GNT_A;
                        r_s     <= 1'b0;
                        r_last  <= 1'b0;
                    end else if (w_xfer && !w_b_acc) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign A = r_a;
    assign B = r_b;
    assign S = r_s;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter (WIDTH=2, BURST=4). Inputs change 1ns
// after each rising edge; outputs are sampled 1ns later, mid-cycle.
module tb_mux_sel_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, out_ready;
    logic       a_ready, b_ready, S, out_valid;
    logic [1:0] a_data, b_data, A, B;
    logic [1:0] c_mux;

    int n_chk  = 0;
    int n_pass = 0;

    mux_sel_arbiter #(.WIDTH(2), .BURST(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .A(A), .B(B), .S(S),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    assign c_mux = S ? B : A;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Checks out_valid, and S plus mux output when a word is presented.
    task automatic chk_out(input string tag, input logic ov, input logic s, input logic [1:0] d);
        chk({tag, ".ov"}, out_valid, ov);
        if (ov) begin
            chk({tag, ".S"}, S, s);
            chk({tag, ".C"}, c_mux, d);
        end
    endtask

    task automatic idle_in();
        a_valid = 0; b_valid = 0; a_data = 0; b_data = 0;
    endtask

    // Alternation/burst scenario expectations (cycles c0..c8).
`ifdef MUXARB_BURST_EN
    logic       alt_ov [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
    logic       alt_s  [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    logic [1:0] alt_d  [9] = '{0, 0, 1, 2, 3, 0, 2, 1, 0};
`else
    logic       alt_ov [9] = '{0, 0, 1, 1, 1, 1, 1, 0, 0};
    logic       alt_s  [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    logic [1:0] alt_d  [9] = '{0, 0, 1, 2, 2, 3, 0, 0, 0};
`endif
    logic [1:0] alt_q  [5] = '{1, 2, 3, 0, 1};
    logic [1:0] str_q  [4] = '{0, 1, 2, 3};

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int ai;
        rst_n = 0; out_ready = 0;
        idle_in();
        #3;
        // Reset state
        chk("rst.A", A, 0);
        chk("rst.B", B, 0);
        chk("rst.S", S, 0);
        chk("rst.ov", out_valid, 0);
        chk("rst.a_ready", a_ready, 1);
        chk("rst.b_ready", b_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Tie: A=1 and B=2 together, A first, then B
        out_ready = 1;
        a_valid = 1; a_data = 1; b_valid = 1; b_data = 2;
        tick();
        idle_in(); settle();
        chk_out("tie.c1", 0, 0, 0);
        tick(); chk_out("tie.c2", 1, 0, 1);
        tick(); chk_out("tie.c3", 1, 1, 2);
        tick(); chk_out("tie.c4", 0, 0, 0);
        chk("tie.S_hold", S, 1);

        // Single source: word 3 on A
        a_valid = 1; a_data = 3; settle();
        chk("single.a_ready", a_ready, 1);
        chk("single.ov0", out_valid, 0);
        tick();
        idle_in(); settle();
        chk("single.ov_lat", out_valid, 0);
        chk("single.a_ready_full", a_ready, 0);
        tick();
        chk_out("single.out", 1, 0, 3);
        chk("single.A", A, 3);
        tick();
        chk("single.ov_end", out_valid, 0);
        chk("single.A_kept", A, 3);

        // Alternation / burst: A streams, B=2 arrives one cycle later
        ai = 0;
        for (int c = 0; c < 9; c++) begin
            if (c <= 5 && ai < 5) begin a_valid = 1; a_data = alt_q[ai]; end
            else begin a_valid = 0; a_data = 0; end
            b_valid = (c == 1); b_data = (c == 1) ? 2'd2 : 2'd0;
            settle();
            chk_out($sformatf("alt.c%0d", c), alt_ov[c], alt_s[c], alt_d[c]);
            if (a_valid && a_ready) ai++;
            tick();
        end
        idle_in();

        // Stall in GNT_B with B=3 while an A word arrives
        out_ready = 0;
        b_valid = 1; b_data = 3; settle();
        chk("stall.b_ready0", b_ready, 1);
        tick();
        idle_in(); settle();
        chk("stall.ov_pre", out_valid, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            a_valid = (c == 0); a_data = (c == 0) ? 2'd1 : 2'd0;
            settle();
            chk_out($sformatf("stall.c%0d", c), 1, 1, 3);
            chk($sformatf("stall.B%0d", c), B, 3);
            chk($sformatf("stall.b_ready%0d", c), b_ready, 0);
            chk($sformatf("stall.a_ready%0d", c), a_ready, (c == 0));
            tick();
        end
        idle_in();
        out_ready = 1; settle();
        chk_out("stall.rel", 1, 1, 3);
        chk("stall.b_ready_rel", b_ready, 1);
        tick(); chk_out("stall.a", 1, 0, 1);
        tick(); chk_out("stall.end", 0, 0, 0);

        // Stream 0,1,2,3 on A: transfers on consecutive cycles
        ai = 0;
        for (int c = 0; c < 7; c++) begin
            if (ai < 4) begin a_valid = 1; a_data = str_q[ai]; end
            else begin a_valid = 0; a_data = 0; end
            settle();
            if (c >= 2 && c <= 5) chk_out($sformatf("stream.c%0d", c), 1, 0, 2'(c - 2));
            else chk_out($sformatf("stream.c%0d", c), 0, 0, 0);
            if (a_valid && a_ready) ai++;
            tick();
        end
        chk("stream.count", ai, 4);
        idle_in();

        // Reset while in GNT_A with both slots full
        out_ready = 0;
        a_valid = 1; a_data = 2; tick();
        a_valid = 0; b_valid = 1; b_data = 1; settle();
        chk("mrst.b_ready", b_ready, 1);
        tick();
        idle_in(); settle();
        chk_out("mrst.gnt", 1, 0, 2);
        chk("mrst.b_ready_full", b_ready, 0);
        #2 rst_n = 0;
        #1;
        chk("mrst.A", A, 0);
        chk("mrst.B", B, 0);
        chk("mrst.S", S, 0);
        chk("mrst.ov", out_valid, 0);
        chk("mrst.a_ready", a_ready, 1);
        chk("mrst.b_ready_rst", b_ready, 1);
        tick();
        rst_n = 1;
        out_ready = 1;
        a_valid = 1; a_data = 3; b_valid = 1; b_data = 1;
        tick();
        idle_in(); tick();
        chk_out("mrst.tieA", 1, 0, 3);
        tick(); chk_out("mrst.tieB", 1, 1, 1);
        tick(); chk_out("mrst.end", 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
